// File: rtl/pong_pkg.sv
// Shared encodings for the pong score keeper: FSM states, winner codes and BCD helpers.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2
    } winner_t;

    localparam logic [7:0] BCD_MAX = 8'h99;

    // Saturating two-digit BCD increment.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == BCD_MAX) begin
            r = BCD_MAX;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [6:0] bcd_to_bin(input logic [7:0] v);
        logic [6:0] tens;
        tens = {3'b000, v[7:4]};
        return (tens << 3) + (tens << 1) + {3'b000, v[3:0]};
    endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Handshake/status bundle between the ball stage, the score keeper and the HUD.
interface score_keeper_if;
    logic       i_ani_stb;
    logic       i_start;
    logic       i_goal_p1;
    logic       i_goal_p2;
    logic       o_animate;
    logic       o_serve;
    logic [7:0] o_score_p1;
    logic [7:0] o_score_p2;
    logic       o_game_over;
    logic [1:0] o_winner;

    modport master (
        output i_ani_stb, i_start, i_goal_p1, i_goal_p2,
        input  o_animate, o_serve, o_score_p1, o_score_p2, o_game_over, o_winner
    );

    modport slave (
        input  i_ani_stb, i_start, i_goal_p1, i_goal_p2,
        output o_animate, o_serve, o_score_p1, o_score_p2, o_game_over, o_winner
    );
endinterface

// File: rtl/bcd_counter2.sv
// Two-digit saturating BCD counter (00..99) with synchronous clear and a binary view.
module bcd_counter2
    import pong_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_inc,
    output logic [7:0] o_bcd,
    output logic [6:0] o_bin
);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_bcd <= 8'h00;
        end else if (i_clr) begin
            o_bcd <= 8'h00;
        end else if (i_inc) begin
            o_bcd <= bcd_inc(o_bcd);
        end
    end

    assign o_bin = bcd_to_bin(o_bcd);

endmodule

// File: rtl/score_keeper.sv
// Match score FSM: gates ball motion, pauses for a serve after each goal, declares a winner.
// Define SCORE_WIN_BY_TWO_EN to require a two-point lead (99 still ends the match).
module score_keeper
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_TICKS = 120
) (
    input  logic           i_clk,
    input  logic           i_rst,
    score_keeper_if.slave  bus
);

    localparam int         CW       = $clog2(SERVE_TICKS + 1);
    localparam logic [CW-1:0] LOAD  = CW'(SERVE_TICKS);
    localparam logic [7:0] WIN_BIN  = 8'(WIN_SCORE);

    state_t        state;
    logic [CW-1:0] serve_cnt;
    logic          prev_p1, prev_p2;
    logic          animate, serve, game_over;
    winner_t       winner;

    logic [7:0]    bcd_p1, bcd_p2;
    logic [6:0]    bin_p1, bin_p2;
    logic          edge_p1, edge_p2;
    logic          inc_p1, inc_p2, clr;
    logic [7:0]    nxt_p1, nxt_p2;
    logic          win_p1, win_p2, win;

    assign edge_p1 = bus.i_goal_p1 & ~prev_p1;
    assign edge_p2 = bus.i_goal_p2 & ~prev_p2;

    // Player 1 takes priority when both goals arrive together.
    assign inc_p1 = (state == ST_PLAY) & edge_p1;
    assign inc_p2 = (state == ST_PLAY) & edge_p2 & ~edge_p1;
    assign clr    = bus.i_start & ((state == ST_IDLE) | (state == ST_OVER));

    assign nxt_p1 = {1'b0, bin_p1} + ((bin_p1 == 7'd99) ? 8'd0 : 8'd1);
    assign nxt_p2 = {1'b0, bin_p2} + ((bin_p2 == 7'd99) ? 8'd0 : 8'd1);

`ifdef SCORE_WIN_BY_TWO_EN
    assign win_p1 = (nxt_p1 >= WIN_BIN) &&
                    ((nxt_p1 >= {1'b0, bin_p2} + 8'd2) || (nxt_p1 == 8'd99));
    assign win_p2 = (nxt_p2 >= WIN_BIN) &&
                    ((nxt_p2 >= {1'b0, bin_p1} + 8'd2) || (nxt_p2 == 8'd99));
`else
    assign win_p1 = nxt_p1 >= WIN_BIN;
    assign win_p2 = nxt_p2 >= WIN_BIN;
`endif

    assign win = (inc_p1 & win_p1) | (inc_p2 & win_p2);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            serve_cnt <= '0;
            prev_p1   <= 1'b0;
            prev_p2   <= 1'b0;
            animate   <= 1'b0;
            serve     <= 1'b0;
            game_over <= 1'b0;
            winner    <= WIN_NONE;
        end else begin
            prev_p1 <= bus.i_goal_p1;
            prev_p2 <= bus.i_goal_p2;
            case (state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        state     <= ST_SERVE;
                        serve     <= 1'b1;
                        serve_cnt <= LOAD;
                    end
                end
                ST_SERVE: begin
                    if (bus.i_ani_stb) begin
                        serve_cnt <= serve_cnt - 1'b1;
                        if (serve_cnt == CW'(1)) begin
                            state   <= ST_PLAY;
                            serve   <= 1'b0;
                            animate <= 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (inc_p1 | inc_p2) begin
                        animate <= 1'b0;
                        if (win) begin
                            state     <= ST_OVER;
                            game_over <= 1'b1;
                            winner    <= inc_p1 ? WIN_P1 : WIN_P2;
                        end else begin
                            state     <= ST_SERVE;
                            serve     <= 1'b1;
                            serve_cnt <= LOAD;
                        end
                    end
                end
                ST_OVER: begin
                    if (bus.i_start) begin
                        state     <= ST_SERVE;
                        game_over <= 1'b0;
                        winner    <= WIN_NONE;
                        serve     <= 1'b1;
                        serve_cnt <= LOAD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    bcd_counter2 u_cnt_p1 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (clr),
        .i_inc (inc_p1),
        .o_bcd (bcd_p1),
        .o_bin (bin_p1)
    );

    bcd_counter2 u_cnt_p2 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (clr),
        .i_inc (inc_p2),
        .o_bcd (bcd_p2),
        .o_bin (bin_p2)
    );

    assign bus.o_animate   = animate;
    assign bus.o_serve     = serve;
    assign bus.o_game_over = game_over;
    assign bus.o_winner    = winner;
    assign bus.o_score_p1  = bcd_p1;
    assign bus.o_score_p2  = bcd_p2;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: a WIN_SCORE=7 and a WIN_SCORE=12 instance share stimulus.
module tb_score_keeper;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ani_stb = 1'b0;
    logic start = 1'b0;
    logic goal_p1 = 1'b0;
    logic goal_p2 = 1'b0;
    bit   sel = 1'b0;
    int   checks = 0;
    int   errors = 0;

    score_keeper_if if7 ();
    score_keeper_if if12 ();

    assign if7.i_ani_stb  = ani_stb;
    assign if7.i_start    = start;
    assign if7.i_goal_p1  = goal_p1;
    assign if7.i_goal_p2  = goal_p2;
    assign if12.i_ani_stb = ani_stb;
    assign if12.i_start   = start;
    assign if12.i_goal_p1 = goal_p1;
    assign if12.i_goal_p2 = goal_p2;

    score_keeper #(.WIN_SCORE(7), .SERVE_TICKS(4)) dut7 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if7)
    );

    score_keeper #(.WIN_SCORE(12), .SERVE_TICKS(4)) dut12 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if12)
    );

    always #5 clk = ~clk;

    // One strobe every fourth cycle.
    initial begin
        int phase;
        phase = 0;
        forever begin
            @(negedge clk);
            ani_stb = (phase == 3);
            phase = (phase + 1) % 4;
        end
    end

    typedef struct {
        bit         g1;
        bit         g2;
        logic [7:0] e1;
        logic [7:0] e2;
        logic       e_over;
        logic [1:0] e_win;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic anim_sel();
        return sel ? if12.o_animate : if7.o_animate;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_play(input string name);
        int n;
        n = 0;
        while (!anim_sel() && n < 200) begin
            tick();
            n++;
        end
        chk({name, "_reach_play"}, 32'(anim_sel()), 32'd1);
    endtask

    task automatic goal(input bit g1, input bit g2);
        goal_p1 = g1;
        goal_p2 = g2;
        tick();
        goal_p1 = 1'b0;
        goal_p2 = 1'b0;
    endtask

    task automatic restart();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int   strobes;
        int   n;
        int   serve_strobes;
        logic any_anim;

        vecs[0] = '{1, 0, 8'h01, 8'h00, 0, 2'd0};
        vecs[1] = '{0, 1, 8'h01, 8'h01, 0, 2'd0};
        vecs[2] = '{1, 1, 8'h02, 8'h01, 0, 2'd0};
        vecs[3] = '{1, 0, 8'h03, 8'h01, 0, 2'd0};
        vecs[4] = '{0, 1, 8'h03, 8'h02, 0, 2'd0};
        vecs[5] = '{1, 0, 8'h04, 8'h02, 0, 2'd0};
        vecs[6] = '{1, 0, 8'h05, 8'h02, 0, 2'd0};
        vecs[7] = '{1, 0, 8'h06, 8'h02, 0, 2'd0};
        vecs[8] = '{1, 0, 8'h07, 8'h02, 1, 2'd1};

        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_animate", 32'(if7.o_animate), 32'd0);
        chk("rst_serve", 32'(if7.o_serve), 32'd0);
        chk("rst_scores", {16'd0, if7.o_score_p1, if7.o_score_p2}, 32'd0);
        chk("rst_over_win", {29'd0, if7.o_game_over, if7.o_winner}, 32'd0);
        tick();
        rst = 1'b0;

        // No start: stays idle through 1000 strobes
        strobes = 0;
        n = 0;
        any_anim = 1'b0;
        while (strobes < 1000 && n < 5000) begin
            tick();
            if (ani_stb) strobes++;
            any_anim = any_anim | if7.o_animate | if7.o_serve;
            n++;
        end
        chk("idle_strobes", 32'(strobes), 32'd1000);
        chk("idle_never_moves", 32'(any_anim), 32'd0);
        chk("idle_scores", {16'd0, if7.o_score_p1, if7.o_score_p2}, 32'd0);

        // Start: serve lasts exactly SERVE_TICKS strobes
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_serve", 32'(if7.o_serve), 32'd1);
        serve_strobes = 0;
        n = 0;
        while (!if7.o_animate && n < 100) begin
            if (if7.o_serve && ani_stb) serve_strobes++;
            tick();
            n++;
        end
        chk("serve_strobe_count", 32'(serve_strobes), 32'd4);
        chk("play_animate", 32'(if7.o_animate), 32'd1);
        chk("play_serve_low", 32'(if7.o_serve), 32'd0);

        // Goal flag held for 50 cycles counts once
        goal_p1 = 1'b1;
        tick();
        chk("hold_first_score", 32'(if7.o_score_p1), 32'h01);
        chk("hold_serve", 32'(if7.o_serve), 32'd1);
        chk("hold_animate_low", 32'(if7.o_animate), 32'd0);
        for (int i = 0; i < 49; i++) tick();
        chk("hold_single_count", 32'(if7.o_score_p1), 32'h01);
        chk("hold_back_in_play", 32'(if7.o_animate), 32'd1);
        goal_p1 = 1'b0;
        tick();

        // BCD carry on the WIN_SCORE=12 instance
        restart();
        sel = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            wait_play("bcd");
            goal(0, 1);
            chk($sformatf("bcd_step%0d", i), 32'(if12.o_score_p2), 32'(to_bcd(i)));
        end
        chk("bcd_not_over", 32'(if12.o_game_over), 32'd0);
        chk("bcd_p1_zero", 32'(if12.o_score_p1), 32'h00);

        // Table: scoring, simultaneous goals, win at 7
        restart();
        sel = 1'b0;
        foreach (vecs[i]) begin
            wait_play("vec");
            goal(vecs[i].g1, vecs[i].g2);
            chk($sformatf("vec%0d_p1", i), 32'(if7.o_score_p1), 32'(vecs[i].e1));
            chk($sformatf("vec%0d_p2", i), 32'(if7.o_score_p2), 32'(vecs[i].e2));
            chk($sformatf("vec%0d_over", i), 32'(if7.o_game_over), 32'(vecs[i].e_over));
            chk($sformatf("vec%0d_winner", i), 32'(if7.o_winner), 32'(vecs[i].e_win));
            chk($sformatf("vec%0d_serve", i), 32'(if7.o_serve), 32'(!vecs[i].e_over));
            chk($sformatf("vec%0d_animate", i), 32'(if7.o_animate), 32'd0);
        end

        // Goals after game over are ignored
        for (int i = 0; i < 20; i++) tick();
        goal(1, 1);
        tick();
        goal(0, 1);
        for (int i = 0; i < 20; i++) tick();
        chk("over_scores_held", {16'd0, if7.o_score_p1, if7.o_score_p2}, 32'h0702);
        chk("over_winner_held", 32'(if7.o_winner), 32'd1);
        chk("over_no_animate", 32'(if7.o_animate), 32'd0);

        // Restart from OVER clears everything
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rematch_serve", 32'(if7.o_serve), 32'd1);
        chk("rematch_clear", {16'd0, if7.o_score_p1, if7.o_score_p2}, 32'd0);
        chk("rematch_winner", {29'd0, if7.o_game_over, if7.o_winner}, 32'd0);

        // Deuce: 6-6 then player 1 scores
        for (int i = 0; i < 6; i++) begin
            wait_play("deuce");
            goal(1, 0);
            wait_play("deuce");
            goal(0, 1);
        end
        chk("deuce_66", {16'd0, if7.o_score_p1, if7.o_score_p2}, 32'h0606);
        wait_play("deuce");
        goal(1, 0);
        chk("deuce_76", {16'd0, if7.o_score_p1, if7.o_score_p2}, 32'h0706);
`ifdef SCORE_WIN_BY_TWO_EN
        chk("deuce_76_continues", 32'(if7.o_game_over), 32'd0);
        wait_play("deuce");
        goal(1, 0);
        chk("deuce_86", {16'd0, if7.o_score_p1, if7.o_score_p2}, 32'h0806);
        chk("deuce_86_over", 32'(if7.o_game_over), 32'd1);
        chk("deuce_86_winner", 32'(if7.o_winner), 32'd1);
`else
        chk("first_to_7_over", 32'(if7.o_game_over), 32'd1);
        chk("first_to_7_winner", 32'(if7.o_winner), 32'd1);
`endif

        // Reset mid-play drops animate with no clock edge
        restart();
        wait_play("midrst");
        chk("midrst_pre", 32'(if7.o_animate), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_animate", 32'(if7.o_animate), 32'd0);
        chk("midrst_state", {29'd0, if7.o_serve, if7.o_winner}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
